// File: rtl/frame_sum_accumulator.sv
// Integrates ACC_LEN consecutive adder sums into one frame total behind a one-deep valid/ready register.
// Optional ACC_SATURATE_EN: clamp each add to the WIDTH_ACC range and flag it on acc_sat.
module frame_sum_accumulator #(
  parameter int unsigned WIDTH_IN  = 22,
  parameter int unsigned IS_SIGNED = 0,
  parameter int unsigned IN_DELAY  = 5,
  parameter int unsigned ACC_LEN   = 8,
  parameter int unsigned WIDTH_ACC = 25
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [WIDTH_IN-1:0]  din,
  input  logic                 clear,
  output logic [WIDTH_ACC-1:0] acc_out,
  output logic                 acc_valid,
  input  logic                 acc_ready,
  output logic                 acc_sat,
  output logic                 overrun
);

  localparam int unsigned CNT_W = (ACC_LEN > 2) ? $clog2(ACC_LEN) : 1;
  localparam int unsigned EXT_W = WIDTH_ACC + 1;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t               state, state_nxt;
  logic [IN_DELAY-1:0]  dly;
  logic                 s_valid_c;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [WIDTH_ACC-1:0] acc, acc_nxt;
  logic                 sat_run, sat_run_nxt;
  logic [EXT_W-1:0]     din_ext_c, acc_ext_c, sum_c;
  logic [WIDTH_ACC-1:0] add_res_c;
  logic                 add_clamp_c, sat_frame_c, frame_done_c;

  // ena delay line recovers the validity of the adder's output sample
  generate
    if (IN_DELAY == 1) begin : g_dly1
      always_ff @(posedge clk) begin
        if (rst) dly <= '0;
        else     dly <= ena;
      end
    end else begin : g_dlyn
      always_ff @(posedge clk) begin
        if (rst) dly <= '0;
        else     dly <= {dly[IN_DELAY-2:0], ena};
      end
    end
  endgenerate

  assign s_valid_c = dly[IN_DELAY-1];

  generate
    if (IS_SIGNED != 0) begin : g_sext
      assign din_ext_c = {{(EXT_W-WIDTH_IN){din[WIDTH_IN-1]}}, din};
      assign acc_ext_c = {acc[WIDTH_ACC-1], acc};
    end else begin : g_zext
      assign din_ext_c = {{(EXT_W-WIDTH_IN){1'b0}}, din};
      assign acc_ext_c = {1'b0, acc};
    end
  endgenerate

  // first sample of a frame loads rather than adds
  assign sum_c = ((cnt == '0) ? '0 : acc_ext_c) + din_ext_c;

`ifdef ACC_SATURATE_EN
  always_comb begin
    add_clamp_c = 1'b0;
    add_res_c   = sum_c[WIDTH_ACC-1:0];
    if (IS_SIGNED != 0) begin
      if (sum_c[WIDTH_ACC] != sum_c[WIDTH_ACC-1]) begin
        add_clamp_c = 1'b1;
        add_res_c   = sum_c[WIDTH_ACC] ? {1'b1, {(WIDTH_ACC-1){1'b0}}}
                                       : {1'b0, {(WIDTH_ACC-1){1'b1}}};
      end
    end else if (sum_c[WIDTH_ACC]) begin
      add_clamp_c = 1'b1;
      add_res_c   = '1;
    end
  end
`else
  logic unused_carry;
  assign unused_carry = sum_c[WIDTH_ACC];
  assign add_clamp_c  = 1'b0;
  assign add_res_c    = sum_c[WIDTH_ACC-1:0];
`endif

  // clamp flag accumulates across the frame; restarts on a frame's first sample
  assign sat_frame_c = add_clamp_c | ((cnt == '0) ? 1'b0 : sat_run);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      sat_run   <= 1'b0;
      acc_out   <= '0;
      acc_valid <= 1'b0;
      acc_sat   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      acc     <= acc_nxt;
      sat_run <= sat_run_nxt;
      if (frame_done_c) begin
        acc_out   <= add_res_c;
        acc_sat   <= sat_frame_c;
        acc_valid <= 1'b1;
        if (acc_valid && !acc_ready) overrun <= 1'b1;
      end else if (acc_valid && acc_ready) begin
        acc_valid <= 1'b0;
      end
    end
  end

  // next-state: consume samples on s_valid, clear flushes the partial frame
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    acc_nxt      = acc;
    sat_run_nxt  = sat_run;
    frame_done_c = 1'b0;
    case (state)
      IDLE:    if (s_valid_c) state_nxt = ACCUM;
      ACCUM:   state_nxt = ACCUM;
      default: state_nxt = IDLE;
    endcase
    if (s_valid_c) begin
      acc_nxt = add_res_c;
      if (cnt == CNT_W'(ACC_LEN - 1)) begin
        cnt_nxt      = '0;
        sat_run_nxt  = 1'b0;
        frame_done_c = 1'b1;
      end else begin
        cnt_nxt     = CNT_W'(cnt + 1'b1);
        sat_run_nxt = sat_frame_c;
      end
    end
    if (clear) begin
      state_nxt    = IDLE;
      cnt_nxt      = '0;
      acc_nxt      = '0;
      sat_run_nxt  = 1'b0;
      frame_done_c = 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_sum_accumulator.sv
// Scoreboard bench: one unsigned (WIDTH_ACC=23) and one signed (WIDTH_ACC=25) instance share stimulus.
module tb_frame_sum_accumulator;
  localparam int unsigned WIN = 22;
  localparam int unsigned D   = 5;
  localparam int unsigned LEN = 4;
  localparam int unsigned WU  = 23;
  localparam int unsigned WS  = 25;

  logic           clk = 1'b0;
  logic           rst, ena, clear, acc_ready;
  logic [WIN-1:0] din;
  logic [WU-1:0]  u_out;
  logic [WS-1:0]  s_out;
  logic           u_valid, u_sat, u_ovr, s_valid, s_sat, s_ovr;

  int n_cmp = 0;
  int n_bad = 0;
  logic [25:0]    uq[$];
  logic [25:0]    sq[$];
  logic [WIN-1:0] pipe [0:D];

  always #5 clk = ~clk;

  frame_sum_accumulator #(.WIDTH_IN(WIN), .IS_SIGNED(0), .IN_DELAY(D), .ACC_LEN(LEN), .WIDTH_ACC(WU)) u_dut (
    .clk(clk), .rst(rst), .ena(ena), .din(din), .clear(clear), .acc_out(u_out),
    .acc_valid(u_valid), .acc_ready(acc_ready), .acc_sat(u_sat), .overrun(u_ovr));

  frame_sum_accumulator #(.WIDTH_IN(WIN), .IS_SIGNED(1), .IN_DELAY(D), .ACC_LEN(LEN), .WIDTH_ACC(WS)) s_dut (
    .clk(clk), .rst(rst), .ena(ena), .din(din), .clear(clear), .acc_out(s_out),
    .acc_valid(s_valid), .acc_ready(acc_ready), .acc_sat(s_sat), .overrun(s_ovr));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one clock of stimulus; din models the adder, presenting a value D cycles after its ena
  task automatic cyc(input logic e, input logic [WIN-1:0] v, input logic rdy, input logic clr);
    @(negedge clk);
    ena       = e;
    acc_ready = rdy;
    clear     = clr;
    for (int i = D; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = v;
    din     = pipe[D];
  endtask

  task automatic push_exp(input logic [WU-1:0] uv, input logic us, input logic [WS-1:0] sv, input logic ss);
    uq.push_back({us, 25'(uv)});
    sq.push_back({ss, sv});
  endtask

  // monitors: every accepted total is popped and compared
  initial begin : mon_u
    logic [25:0] e;
    forever begin
      @(negedge clk); #1;
      if (u_valid && acc_ready) begin
        if (uq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL u_unexpected: got %0h expected none", u_out);
        end else begin
          e = uq.pop_front();
          check("u_total", 32'({u_sat, 25'(u_out)}), 32'(e));
        end
      end
    end
  end

  initial begin : mon_s
    logic [25:0] e;
    forever begin
      @(negedge clk); #1;
      if (s_valid && acc_ready) begin
        if (sq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL s_unexpected: got %0h expected none", s_out);
        end else begin
          e = sq.pop_front();
          check("s_total", 32'({s_sat, s_out}), 32'(e));
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_u_out"}, 32'(u_out), 0);
    check({tag, "_s_out"}, 32'(s_out), 0);
    check({tag, "_u_valid"}, 32'(u_valid), 0);
    check({tag, "_s_valid"}, 32'(s_valid), 0);
    check({tag, "_u_sat"}, 32'(u_sat), 0);
    check({tag, "_u_ovr"}, 32'(u_ovr), 0);
    check({tag, "_s_ovr"}, 32'(s_ovr), 0);
  endtask

  initial begin
    logic [6:0] pat;
    rst = 1'b1; ena = 1'b0; clear = 1'b0; acc_ready = 1'b1; din = '0;
    for (int i = 0; i <= D; i++) pipe[i] = '0;
    repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);
    check_zero("reset");
    rst = 1'b0;

    // basic frame 1+2+3+4 with latency check
    push_exp(23'd10, 1'b0, 25'd10, 1'b0);
    for (int i = 0; i < 12; i++) begin
      cyc(i < 4, (i < 4) ? WIN'(i + 1) : '0, 1'b1, 1'b0);
      if (i == 3 + D) check("lat_pre", 32'(u_valid), 0);
      if (i == 4 + D) begin
        check("lat_hit", 32'(u_valid), 1);
        check("lat_val", 32'(u_out), 10);
      end
    end

    // all-ones input: unsigned wraps or clamps, signed is -4; next frame starts fresh
`ifdef ACC_SATURATE_EN
    push_exp(23'h7FFFFF, 1'b1, 25'h1FFFFFC, 1'b0);
`else
    push_exp(23'h7FFFFC, 1'b0, 25'h1FFFFFC, 1'b0);
`endif
    push_exp(23'd4, 1'b0, 25'd4, 1'b0);
    for (int i = 0; i < 14; i++)
      cyc(i < 8, (i < 4) ? 22'h3FFFFF : 22'd1, 1'b1, 1'b0);

    // backpressure across two frames: first total lost, overrun set
    push_exp(23'd24, 1'b0, 25'd24, 1'b0);
    for (int i = 0; i < 18; i++) begin
      cyc(i < 8, (i < 4) ? 22'd5 : 22'd6, i > 9 + D, 1'b0);
      if (i == 9 + D) begin
        check("bp_u_ovr", 32'(u_ovr), 1);
        check("bp_s_ovr", 32'(s_ovr), 1);
        check("bp_u_out", 32'(u_out), 24);
      end
    end

    rst = 1'b1;
    repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);
    rst = 1'b0;
    check("rst_u_ovr", 32'(u_ovr), 0);

    // accept coincides with next frame load: no overrun
    push_exp(23'd4, 1'b0, 25'd4, 1'b0);
    push_exp(23'd8, 1'b0, 25'd8, 1'b0);
    for (int i = 0; i < 16; i++)
      cyc(i < 8, (i < 4) ? 22'd1 : 22'd2, i >= 7 + D, 1'b0);
    check("co_u_ovr", 32'(u_ovr), 0);
    check("co_s_ovr", 32'(s_ovr), 0);

    // clear after two samples, then a full frame of 5s
    push_exp(23'd20, 1'b0, 25'd20, 1'b0);
    for (int i = 0; i < 22; i++)
      cyc((i < 2) || (i >= 10 && i < 14), (i < 2) ? 22'd7 : 22'd5, 1'b1, i == 8);

    // reset with samples still in flight
    for (int i = 0; i < 3; i++) cyc(i < 2, 22'd9, 1'b1, 1'b0);
    rst = 1'b1;
    repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);
    check_zero("midrst");
    rst = 1'b0;
    push_exp(23'd4, 1'b0, 25'd4, 1'b0);
    for (int i = 0; i < 12; i++) cyc(i < 4, 22'd1, 1'b1, 1'b0);

    // ena gaps
    pat = 7'b1011001;
    push_exp(23'd4, 1'b0, 25'd4, 1'b0);
    for (int i = 0; i < 16; i++) begin
      cyc((i < 7) ? pat[i] : 1'b0, 22'd1, 1'b1, 1'b0);
      if (i == 6 + D) check("gap_pre", 32'(u_valid), 0);
      if (i == 7 + D) begin
        check("gap_hit", 32'(u_valid), 1);
        check("gap_val", 32'(u_out), 4);
      end
    end

    repeat (4) cyc(1'b0, '0, 1'b1, 1'b0);
    check("u_queue_left", 32'(uq.size()), 0);
    check("s_queue_left", 32'(sq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
